// File: rtl/rvc_pkg.sv
// Shared constants for the RVC fetch aligner: compressed quadrant/funct3 codes,
// RV32I opcodes and the aligner FSM state encoding.
package rvc_pkg;

  localparam logic [1:0] Q0 = 2'b00;
  localparam logic [1:0] Q1 = 2'b01;
  localparam logic [1:0] Q2 = 2'b10;

  localparam logic [2:0] F3_ADDI4SPN = 3'b000;
  localparam logic [2:0] F3_LW       = 3'b010;
  localparam logic [2:0] F3_SW       = 3'b110;
  localparam logic [2:0] F3_ADDI     = 3'b000;
  localparam logic [2:0] F3_JAL      = 3'b001;
  localparam logic [2:0] F3_LI       = 3'b010;
  localparam logic [2:0] F3_LUI      = 3'b011;
  localparam logic [2:0] F3_ALU      = 3'b100;
  localparam logic [2:0] F3_J        = 3'b101;
  localparam logic [2:0] F3_BEQZ     = 3'b110;
  localparam logic [2:0] F3_BNEZ     = 3'b111;
  localparam logic [2:0] F3_SLLI     = 3'b000;
  localparam logic [2:0] F3_LWSP     = 3'b010;
  localparam logic [2:0] F3_JR       = 3'b100;
  localparam logic [2:0] F3_SWSP     = 3'b110;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  typedef enum logic {
    ST_ALIGNED = 1'b0,
    ST_CARRY   = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/rvc_expand.sv
// Combinational RV32C -> RV32I expander; illegal encodings expand to all-zero.
// The illegal flag port exists only when RVC_ILLEGAL_EN is defined.
module rvc_expand
  import rvc_pkg::*;
(
  input  logic [15:0] hw,
  output logic [31:0] instr_x
`ifdef RVC_ILLEGAL_EN
  ,
  output logic        illegal
`endif
);

  logic [4:0]  rd_s, rs2_s, rdp_s, rs1p_s;
  logic [11:0] imm6_s, a4spn_s, lsw_imm_s, lwsp_imm_s, swsp_imm_s, a16_imm_s;
  logic [20:0] j_imm_s;
  logic [12:0] b_imm_s;
  logic [31:0] exp_s;
  logic        ill_s;

  assign rd_s       = hw[11:7];
  assign rs2_s      = hw[6:2];
  assign rdp_s      = {2'b01, hw[4:2]};
  assign rs1p_s     = {2'b01, hw[9:7]};
  assign imm6_s     = {{7{hw[12]}}, hw[6:2]};
  assign a4spn_s    = {2'b00, hw[10:7], hw[12:11], hw[5], hw[6], 2'b00};
  assign lsw_imm_s  = {5'b00000, hw[5], hw[12:10], hw[6], 2'b00};
  assign lwsp_imm_s = {4'b0000, hw[3:2], hw[12], hw[6:4], 2'b00};
  assign swsp_imm_s = {4'b0000, hw[8:7], hw[12:9], 2'b00};
  assign a16_imm_s  = {{3{hw[12]}}, hw[4:3], hw[5], hw[2], hw[6], 4'b0000};
  assign j_imm_s    = {{10{hw[12]}}, hw[8], hw[10:9], hw[6], hw[7], hw[2], hw[11], hw[5:3], 1'b0};
  assign b_imm_s    = {{5{hw[12]}}, hw[6:5], hw[2], hw[11:10], hw[4:3], 1'b0};

  // Decode quadrant/funct3 into the equivalent 32-bit encoding.
  always_comb begin
    exp_s = 32'h0000_0000;
    ill_s = 1'b0;
    case (hw[1:0])
      Q0: begin
        case (hw[15:13])
          F3_ADDI4SPN: begin
            exp_s = {a4spn_s, 5'd2, 3'b000, rdp_s, OP_IMM};
            ill_s = (hw[12:5] == 8'h00);
          end
          F3_LW:   exp_s = {lsw_imm_s, rs1p_s, 3'b010, rdp_s, OP_LOAD};
          F3_SW:   exp_s = {lsw_imm_s[11:5], rdp_s, rs1p_s, 3'b010, lsw_imm_s[4:0], OP_STORE};
          default: ill_s = 1'b1;
        endcase
      end
      Q1: begin
        case (hw[15:13])
          F3_ADDI: exp_s = {imm6_s, rd_s, 3'b000, rd_s, OP_IMM};
          F3_JAL:  exp_s = {j_imm_s[20], j_imm_s[10:1], j_imm_s[11], j_imm_s[19:12], 5'd1, OP_JAL};
          F3_LI:   exp_s = {imm6_s, 5'd0, 3'b000, rd_s, OP_IMM};
          F3_LUI: begin
            if (rd_s == 5'd2) begin
              exp_s = {a16_imm_s, 5'd2, 3'b000, 5'd2, OP_IMM};
              ill_s = ({hw[12], hw[6:2]} == 6'd0);
            end else begin
              exp_s = {{15{hw[12]}}, hw[6:2], rd_s, OP_LUI};
            end
          end
          F3_ALU: begin
            case (hw[11:10])
              2'b00:   exp_s = {7'b0000000, hw[6:2], rs1p_s, 3'b101, rs1p_s, OP_IMM};
              2'b01:   exp_s = {7'b0100000, hw[6:2], rs1p_s, 3'b101, rs1p_s, OP_IMM};
              2'b10:   exp_s = {imm6_s, rs1p_s, 3'b111, rs1p_s, OP_IMM};
              default: begin
                case ({hw[12], hw[6:5]})
                  3'b000:  exp_s = {7'b0100000, rdp_s, rs1p_s, 3'b000, rs1p_s, OP_REG};
                  3'b001:  exp_s = {7'b0000000, rdp_s, rs1p_s, 3'b100, rs1p_s, OP_REG};
                  3'b010:  exp_s = {7'b0000000, rdp_s, rs1p_s, 3'b110, rs1p_s, OP_REG};
                  3'b011:  exp_s = {7'b0000000, rdp_s, rs1p_s, 3'b111, rs1p_s, OP_REG};
                  default: ill_s = 1'b1;
                endcase
              end
            endcase
          end
          F3_J:    exp_s = {j_imm_s[20], j_imm_s[10:1], j_imm_s[11], j_imm_s[19:12], 5'd0, OP_JAL};
          F3_BEQZ: exp_s = {b_imm_s[12], b_imm_s[10:5], 5'd0, rs1p_s, 3'b000, b_imm_s[4:1], b_imm_s[11], OP_BRANCH};
          F3_BNEZ: exp_s = {b_imm_s[12], b_imm_s[10:5], 5'd0, rs1p_s, 3'b001, b_imm_s[4:1], b_imm_s[11], OP_BRANCH};
          default: ill_s = 1'b1;
        endcase
      end
      Q2: begin
        case (hw[15:13])
          F3_SLLI: exp_s = {7'b0000000, hw[6:2], rd_s, 3'b001, rd_s, OP_IMM};
          F3_LWSP: begin
            exp_s = {lwsp_imm_s, 5'd2, 3'b010, rd_s, OP_LOAD};
            ill_s = (rd_s == 5'd0);
          end
          F3_JR: begin
            if (!hw[12]) begin
              exp_s = (rs2_s == 5'd0) ? {12'h000, rd_s, 3'b000, 5'd0, OP_JALR}
                                      : {7'b0000000, rs2_s, 5'd0, 3'b000, rd_s, OP_REG};
            end else if (rs2_s != 5'd0) begin
              exp_s = {7'b0000000, rs2_s, rd_s, 3'b000, rd_s, OP_REG};
            end else begin
              exp_s = (rd_s == 5'd0) ? INSTR_EBREAK : {12'h000, rd_s, 3'b000, 5'd1, OP_JALR};
            end
          end
          F3_SWSP: exp_s = {swsp_imm_s[11:5], rs2_s, 5'd2, 3'b010, swsp_imm_s[4:0], OP_STORE};
          default: ill_s = 1'b1;
        endcase
      end
      default: ill_s = 1'b1;
    endcase
  end

  assign instr_x = ill_s ? 32'h0000_0000 : exp_s;
`ifdef RVC_ILLEGAL_EN
  assign illegal = ill_s;
`endif

endmodule

// File: rtl/rvc_fetch_aligner.sv
// Fetch-word queue + ALIGNED/CARRY realignment FSM with a registered instruction output.
// Optional RVC_ILLEGAL_EN adds the instr_illegal output.
module rvc_fetch_aligner
  import rvc_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  input  logic [31:0] fetch_pc,
  input  logic        flush,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        instr_is_compressed
`ifdef RVC_ILLEGAL_EN
  ,
  output logic        instr_illegal
`endif
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0] q_data_r [DEPTH];
  logic [31:0] q_pc_r   [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r;
  fsm_state_e    state_r, state_s;
  logic [15:0]   carry_r;
  logic [31:0]   carry_pc_r;
  logic          hw_sel_r, hw_sel_s, first_r;
  logic          out_valid_r, out_comp_r;
  logic [31:0]   out_data_r, out_pc_r;

  logic        push_s, pop_s, head_valid_s, load_ok_s, carry_ld_s;
  logic        emit_s, emit_comp_s;
  logic [31:0] emit_data_s, emit_pc_s, head_data_s, head_pc_s, exp_data_s;
  logic [15:0] half_s;

  assign fetch_ready  = (count_r < FULL_CNT);
  assign push_s       = fetch_valid && fetch_ready && !flush;
  assign head_valid_s = (count_r != '0);
  assign head_data_s  = q_data_r[rd_ptr_r];
  assign head_pc_s    = q_pc_r[rd_ptr_r];
  assign half_s       = hw_sel_r ? head_data_s[31:16] : head_data_s[15:0];
  assign load_ok_s    = !out_valid_r || instr_ready;

`ifdef RVC_ILLEGAL_EN
  logic exp_ill_s, out_ill_r;
  rvc_expand u_expand (.hw(half_s), .instr_x(exp_data_s), .illegal(exp_ill_s));
`else
  rvc_expand u_expand (.hw(half_s), .instr_x(exp_data_s));
`endif

  // Choose the next instruction from the head halfword or the carried upper halfword.
  always_comb begin
    emit_s      = 1'b0;
    emit_data_s = 32'h0000_0000;
    emit_pc_s   = 32'h0000_0000;
    emit_comp_s = 1'b0;
    pop_s       = 1'b0;
    carry_ld_s  = 1'b0;
    hw_sel_s    = hw_sel_r;
    state_s     = state_r;
    case (state_r)
      ST_ALIGNED: begin
        if (!head_valid_s) begin
          emit_s = 1'b0;
        end else if (half_s[1:0] != 2'b11) begin
          emit_s      = load_ok_s;
          emit_data_s = exp_data_s;
          emit_pc_s   = {head_pc_s[31:2], head_pc_s[1] | hw_sel_r, head_pc_s[0]};
          emit_comp_s = 1'b1;
          pop_s       = load_ok_s && hw_sel_r;
          hw_sel_s    = load_ok_s ? !hw_sel_r : hw_sel_r;
        end else if (!hw_sel_r) begin
          emit_s      = load_ok_s;
          emit_data_s = head_data_s;
          emit_pc_s   = head_pc_s;
          pop_s       = load_ok_s;
        end else begin
          // Upper halfword opens a 32-bit instruction: park it and free the word.
          carry_ld_s = 1'b1;
          pop_s      = 1'b1;
          hw_sel_s   = 1'b0;
          state_s    = ST_CARRY;
        end
      end
      ST_CARRY: begin
        if (head_valid_s && load_ok_s) begin
          emit_s      = 1'b1;
          emit_data_s = {head_data_s[15:0], carry_r};
          emit_pc_s   = carry_pc_r;
          hw_sel_s    = 1'b1;
          state_s     = ST_ALIGNED;
        end else begin
          emit_s = 1'b0;
        end
      end
      default: state_s = ST_ALIGNED;
    endcase
  end

  // Queue storage; contents are only meaningful below count_r.
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_data_r[wr_ptr_r] <= fetch_data;
      q_pc_r[wr_ptr_r]   <= fetch_pc;
    end
  end

  // Queue pointers, FSM, halfword select and carry register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      state_r    <= ST_ALIGNED;
      hw_sel_r   <= 1'b0;
      first_r    <= 1'b1;
      carry_r    <= 16'h0000;
      carry_pc_r <= 32'h0000_0000;
    end else if (flush) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      state_r    <= ST_ALIGNED;
      hw_sel_r   <= 1'b0;
      first_r    <= 1'b1;
      carry_r    <= 16'h0000;
      carry_pc_r <= 32'h0000_0000;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
      state_r <= state_s;
      // The queue is empty while first_r is set, so the entry offset can seed hw_sel directly.
      if (push_s && first_r) begin
        hw_sel_r <= fetch_pc[1];
        first_r  <= 1'b0;
      end else begin
        hw_sel_r <= hw_sel_s;
      end
      if (carry_ld_s) begin
        carry_r    <= head_data_s[31:16];
        carry_pc_r <= {head_pc_s[31:2], 1'b1, head_pc_s[0]};
      end
    end
  end

  // Registered output stage; holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= 32'h0000_0000;
      out_pc_r    <= RESET_PC;
      out_comp_r  <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (load_ok_s) begin
      out_valid_r <= emit_s;
      if (emit_s) begin
        out_data_r <= emit_data_s;
        out_pc_r   <= emit_pc_s;
        out_comp_r <= emit_comp_s;
      end
    end
  end

`ifdef RVC_ILLEGAL_EN
  // Illegal flag follows the compressed instruction loaded into the output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_ill_r <= 1'b0;
    end else if (flush) begin
      out_ill_r <= 1'b0;
    end else if (load_ok_s && emit_s) begin
      out_ill_r <= emit_comp_s && exp_ill_s;
    end
  end
  assign instr_illegal = out_ill_r;
`endif

  assign instr_valid         = out_valid_r;
  assign instr_data          = out_data_r;
  assign instr_pc            = out_pc_r;
  assign instr_is_compressed = out_comp_r;

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Scoreboard bench for rvc_fetch_aligner: expectations are queued as words are
// driven and compared when the DUT hands an instruction downstream.
module tb_rvc_fetch_aligner;

  logic        clk = 1'b0;
  logic        rst, fetch_valid, fetch_ready, flush;
  logic        instr_valid, instr_ready, instr_is_compressed;
  logic [31:0] fetch_data, fetch_pc, instr_data, instr_pc;
`ifdef RVC_ILLEGAL_EN
  logic        instr_illegal;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        comp;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  always #5 clk = ~clk;

  rvc_fetch_aligner #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_data(fetch_data), .fetch_pc(fetch_pc), .flush(flush),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_is_compressed(instr_is_compressed)
`ifdef RVC_ILLEGAL_EN
    , .instr_illegal(instr_illegal)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic expect_instr(input logic [31:0] d, input logic [31:0] p, input logic c, input logic i);
    exp_t e;
    e.data = d; e.pc = p; e.comp = c; e.ill = i;
    exp_q.push_back(e);
  endtask

  task automatic send_word(input logic [31:0] d, input logic [31:0] p);
    int n = 0;
    fetch_valid = 1'b1; fetch_data = d; fetch_pc = p;
    while (!fetch_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_val("fetch_timeout", 32'(fetch_ready), 32'd1);
    @(negedge clk);
    fetch_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("drain", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Compare every downstream transfer against the head of the scoreboard.
  always @(negedge clk) begin
    #1;
    if (!rst && !flush && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_out", 32'(exp_q.size()), 32'd1);
      end else begin
        cur = exp_q.pop_front();
        check_val("out_data", instr_data, cur.data);
        check_val("out_pc", instr_pc, cur.pc);
        check_val("out_comp", 32'(instr_is_compressed), 32'(cur.comp));
`ifdef RVC_ILLEGAL_EN
        check_val("out_ill", 32'(instr_illegal), 32'(cur.ill));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; fetch_data = 32'h0; fetch_pc = 32'h0;
    flush = 1'b0; instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst_valid", 32'(instr_valid), 32'd0);
    check_val("rst_data", instr_data, 32'h0000_0000);
    check_val("rst_pc", instr_pc, 32'h0000_0000);
    check_val("rst_comp", 32'(instr_is_compressed), 32'd0);
    rst = 1'b0;
    #1 check_val("post_rst_ready", 32'(fetch_ready), 32'd1);

    // Compressed pair, plus output latency from an empty queue
    expect_instr(32'h0000_0513, 32'h100, 1'b1, 1'b0);
    expect_instr(32'h0000_0013, 32'h102, 1'b1, 1'b0);
    send_word(32'h0001_4501, 32'h100);
    check_val("lat_pre", 32'(instr_valid), 32'd0);
    @(negedge clk);
    check_val("lat_post", 32'(instr_valid), 32'd1);
    wait_drain();

    // Straddling 32-bit instruction
    expect_instr(32'h0000_0513, 32'h200, 1'b1, 1'b0);
    expect_instr(32'h0010_0513, 32'h202, 1'b0, 1'b0);
    expect_instr(32'h0000_0013, 32'h206, 1'b1, 1'b0);
    send_word(32'h0513_4501, 32'h200);
    send_word(32'h0001_0010, 32'h204);
    wait_drain();

    // Backpressure: hold outputs, fill queue, release in order
    expect_instr(32'h0010_0513, 32'h500, 1'b0, 1'b0);
    expect_instr(32'h0020_0593, 32'h504, 1'b0, 1'b0);
    expect_instr(32'h0030_0613, 32'h508, 1'b0, 1'b0);
    instr_ready = 1'b0;
    send_word(32'h0010_0513, 32'h500);
    send_word(32'h0020_0593, 32'h504);
    send_word(32'h0030_0613, 32'h508);
    check_val("bp_full_ready", 32'(fetch_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check_val("bp_hold_valid", 32'(instr_valid), 32'd1);
      check_val("bp_hold_data", instr_data, 32'h0010_0513);
      check_val("bp_hold_pc", instr_pc, 32'h500);
      @(negedge clk);
    end
    instr_ready = 1'b1;
    wait_drain();

    // Flush while a carry is parked; the word offered during flush is dropped
    expect_instr(32'h0000_0513, 32'h200, 1'b1, 1'b0);
    send_word(32'h0513_4501, 32'h200);
    wait_drain();
    flush = 1'b1; fetch_valid = 1'b1; fetch_data = 32'h0001_0010; fetch_pc = 32'h204;
    @(negedge clk);
    flush = 1'b0; fetch_valid = 1'b0;
    check_val("flush_valid", 32'(instr_valid), 32'd0);
    check_val("flush_ready", 32'(fetch_ready), 32'd1);
    expect_instr(32'h0000_0513, 32'h302, 1'b1, 1'b0);
    send_word(32'h4501_0000, 32'h302);
    wait_drain();

    // Illegal all-zero halfwords
    expect_instr(32'h0000_0000, 32'h400, 1'b1, 1'b1);
    expect_instr(32'h0000_0000, 32'h402, 1'b1, 1'b1);
    send_word(32'h0000_0000, 32'h400);
    wait_drain();

    // Asynchronous reset mid-stream, then a fresh word
    instr_ready = 1'b0;
    send_word(32'h0010_0513, 32'h600);
    send_word(32'h0020_0593, 32'h604);
    check_val("pre_rst_valid", 32'(instr_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_valid", 32'(instr_valid), 32'd0);
    check_val("async_rst_pc", instr_pc, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0; instr_ready = 1'b1;
    #1;
    check_val("rel_ready", 32'(fetch_ready), 32'd1);
    check_val("rel_valid", 32'(instr_valid), 32'd0);
    expect_instr(32'h0030_0613, 32'h700, 1'b0, 1'b0);
    send_word(32'h0030_0613, 32'h700);
    wait_drain();

    repeat (5) @(negedge clk);
    check_val("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
